// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the PC redirect controller.
// Holds default widths, FSM state encoding and well-known source indices.
package pc_redirect_ctrl_pkg;

  localparam int unsigned PcWidthDflt = 32;
  localparam int unsigned DWidthDflt  = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHold  = 2'd1,
    StFlush = 2'd2
  } rdr_state_e;

  // Conventional source slots; index 0 is the oldest stage and wins ties.
  localparam int unsigned SrcExc = 0;
  localparam int unsigned SrcBr  = 1;
  localparam int unsigned SrcJmp = 2;

  // Width of a binary index over n entries, never zero.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc_onehot.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index and any flag.
module prio_enc_onehot
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned IdxW   = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IdxW-1:0]    idx,
  output logic               any
);

  // Scan from the top so the lowest requesting index is the last write.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IdxW'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: fixed-priority arbitration of redirect sources, a
// registered redirect held under a valid/ready handshake with fetch, and a
// timed IF/ID flush window afterwards.
// Optional build macro PC_REDIRECT_PERF_CNT_EN adds handshake/preempt counters.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned PC_WIDTH     = PcWidthDflt,
  parameter int unsigned DWIDTH       = DWidthDflt,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*PC_WIDTH-1:0] src_pc,
  input  logic [NUM_SRC-1:0]          src_link_en,
  input  logic [NUM_SRC*DWIDTH-1:0]   src_link,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic                        stall_in,
  output logic                        redir_valid,
  output logic [PC_WIDTH-1:0]         redir_pc,
  input  logic                        redir_ready,
  output logic                        link_valid,
  output logic [DWIDTH-1:0]           link_value,
  output logic                        flush_if,
  output logic                        flush_id,
  output logic                        busy,
  output logic [31:0]                 perf_redirects,
  output logic [31:0]                 perf_preempts
);

  localparam int unsigned IdxW = idx_width(NUM_SRC);

  rdr_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0]   link_q, link_d;
  logic                link_en_q, link_en_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [2:0]          cnt_q, cnt_d;

  logic [NUM_SRC-1:0]  win_gnt;
  logic [IdxW-1:0]     win_idx;
  logic                win_any;
  logic                handshake;
  logic                hold_preempt;

  // Same encoder serves the IDLE capture and the HOLD preempt compare.
  prio_enc_onehot #(
    .NUM_SRC(NUM_SRC)
  ) u_prio (
    .req(src_valid),
    .gnt(win_gnt),
    .idx(win_idx),
    .any(win_any)
  );

  assign redir_valid  = (state_q == StHold);
  assign redir_pc     = pc_q;
  assign link_value   = link_q;
  assign busy         = (state_q != StIdle);
  assign handshake    = redir_valid && redir_ready;
  // Handshake beats a same-cycle preempt: the old target is delivered.
  assign hold_preempt = redir_valid && !redir_ready && win_any && (win_idx < idx_q);

  // Next-state, capture and combinational acknowledge/flush outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    link_d     = link_q;
    link_en_d  = link_en_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    src_ready  = '0;
    link_valid = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_any && !stall_in) begin
          pc_d      = src_pc[win_idx*PC_WIDTH +: PC_WIDTH];
          link_d    = src_link[win_idx*DWIDTH +: DWIDTH];
          link_en_d = src_link_en[win_idx];
          idx_d     = win_idx;
          src_ready = win_gnt;
          state_d   = StHold;
        end
      end
      StHold: begin
        if (handshake) begin
          flush_if   = 1'b1;
          flush_id   = 1'b1;
          link_valid = link_en_q;
          cnt_d      = 3'(FLUSH_CYCLES);
          state_d    = (FLUSH_CYCLES == 0) ? StIdle : StFlush;
        end else if (hold_preempt) begin
          // Preemption ignores stall_in: an older redirect must not wait.
          pc_d      = src_pc[win_idx*PC_WIDTH +: PC_WIDTH];
          link_d    = src_link[win_idx*DWIDTH +: DWIDTH];
          link_en_d = src_link_en[win_idx];
          idx_d     = win_idx;
          src_ready = win_gnt;
        end
      end
      StFlush: begin
        flush_if  = 1'b1;
        flush_id  = 1'b1;
        // Wrong-path squash: acknowledge and drop every request.
        src_ready = src_valid;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and captured redirect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      link_q    <= '0;
      link_en_q <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      link_q    <= link_d;
      link_en_q <= link_en_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef PC_REDIRECT_PERF_CNT_EN
  logic [31:0] perf_red_q, perf_pre_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_red_q <= '0;
      perf_pre_q <= '0;
    end else begin
      if (handshake) begin
        perf_red_q <= perf_red_q + 32'd1;
      end
      if (hold_preempt) begin
        perf_pre_q <= perf_pre_q + 32'd1;
      end
    end
  end

  assign perf_redirects = perf_red_q;
  assign perf_preempts  = perf_pre_q;
`else
  assign perf_redirects = '0;
  assign perf_preempts  = '0;
`endif

endmodule
